// File: rtl/fifo_pkg.sv
// Shared defaults for the bit-serial operand FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH  = 32;
  localparam int unsigned FIFO_PREC_W = 5;
  localparam int unsigned FIFO_PTR_W  = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/fifo.sv
// Bit-serial FIFO: pushes one bit per cycle and only starts pops on whole words of
// `precision` bits, so the consumer never sees a partial operand.
import fifo_pkg::*;

module fifo #(
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned PREC_W = FIFO_PREC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              din,
  input  logic [PREC_W-1:0] precision,
  output logic              dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_left_q, rd_left_d;
  logic             rd_active_q, rd_active_d;
  logic             dout_q, dout_d;
  logic [CNT_W-1:0] prec_eff;
  logic             wr_acc, rd_acc;

  // Zero means a 1-bit word; anything beyond the storage is clamped to DEPTH.
  always_comb begin
    if (precision == '0) begin
      prec_eff = CNT_W'(1);
    end else if (32'(precision) > DEPTH) begin
      prec_eff = CNT_W'(DEPTH);
    end else begin
      prec_eff = CNT_W'(precision);
    end
  end

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = !rd_active_q && (count_q < prec_eff);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign dout   = dout_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_left_d   = rd_left_q;
    rd_active_d = rd_active_q;
    dout_d      = dout_q;
    count_d     = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
      if (!rd_active_q) begin
        // Precision is latched here; later changes only affect the next word.
        rd_left_d   = prec_eff - CNT_W'(1);
        rd_active_d = (prec_eff > CNT_W'(1));
      end else begin
        rd_left_d   = rd_left_q - CNT_W'(1);
        rd_active_d = (rd_left_q != CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_left_q   <= '0;
      rd_active_q <= 1'b0;
      dout_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_left_q   <= rd_left_d;
      rd_active_q <= rd_active_d;
      dout_q      <= dout_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for the bit-serial FIFO: queue-based model plus directed vectors.
module tb_fifo;

  localparam int DEPTH  = 32;
  localparam int PREC_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic              din = 1'b0;
  logic [PREC_W-1:0] precision = 5'd4;
  logic              dout, full, empty;

  int n_checks = 0;
  int n_err    = 0;

  fifo #(.DEPTH(DEPTH), .PREC_W(PREC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .din       (din),
    .precision (precision),
    .dout      (dout),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Model: a bit queue plus the number of bits still owed to the word in flight.
  bit q[$];
  int word_left = 0;
  bit m_dout = 1'b0;
  bit m_wacc, m_racc;

  function automatic int peff();
    int p = int'(precision);
    if (p == 0) p = 1;
    if (p > DEPTH) p = DEPTH;
    return p;
  endfunction

  function automatic bit m_full();
    return q.size() == DEPTH;
  endfunction

  function automatic bit m_empty();
    return (word_left == 0) && (q.size() < peff());
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      word_left = 0;
      m_dout = 1'b0;
    end else begin
      m_wacc = wr_en && !m_full();
      m_racc = rd_en && !m_empty();
      if (m_racc) begin
        if (word_left == 0) word_left = peff();
        m_dout = q.pop_front();
        word_left--;
      end
      if (m_wacc) q.push_back(din);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_full", 32'(full), 32'(m_full()));
    check("cmp_empty", 32'(empty), 32'(m_empty()));
    check("cmp_dout", 32'(dout), 32'(m_dout));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input bit b);
    wr_en = 1'b1;
    din   = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_expect(input string name, input bit exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check(name, 32'(dout), 32'(exp));
  endtask

  bit stream[$];
  bit b;

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // T1: reset mid-stream discards old data
    for (int i = 0; i < 4; i++) push(1'b1);
    pop_expect("t1_pre_dout", 1'b1);
    rst = 1'b0;
    #1;
    check("t1_rst_full", 32'(full), 32'd0);
    check("t1_rst_empty", 32'(empty), 32'd1);
    check("t1_rst_dout", 32'(dout), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    push(1'b0); push(1'b0); push(1'b1); push(1'b0);
    pop_expect("t1_rd0", 1'b0);
    pop_expect("t1_rd1", 1'b0);
    pop_expect("t1_rd2", 1'b1);
    pop_expect("t1_rd3", 1'b0);
    check("t1_empty_after", 32'(empty), 32'd1);

    // T2: fill
    for (int i = 0; i < 32; i++) begin
      push(1'(i % 2));
      if (i == 2) check("t2_empty_3w", 32'(empty), 32'd1);
      if (i == 3) check("t2_empty_4w", 32'(empty), 32'd0);
      if (i == 30) check("t2_full_31w", 32'(full), 32'd0);
    end
    check("t2_full_32w", 32'(full), 32'd1);
    push(1'b1);
    check("t2_full_33w", 32'(full), 32'd1);
    check("t2_model_cnt", 32'(q.size()), 32'd32);

    // T3: drain 8, then the rest
    for (int i = 0; i < 8; i++) pop_expect("t3_drain", 1'(i % 2));
    check("t3_model_cnt", 32'(q.size()), 32'd24);
    check("t3_full", 32'(full), 32'd0);
    for (int i = 8; i < 32; i++) pop_expect("t3_rest", 1'(i % 2));
    check("t3_empty", 32'(empty), 32'd1);

    // T4: partial word is not readable
    push(1'b1); push(1'b0); push(1'b1);
    check("t4_empty_3", 32'(empty), 32'd1);
    pop_expect("t4_ignored_rd", 1'b1);
    check("t4_model_cnt", 32'(q.size()), 32'd3);
    push(1'b1);
    check("t4_empty_4", 32'(empty), 32'd0);
    pop_expect("t4_rd0", 1'b1);
    pop_expect("t4_rd1", 1'b0);
    pop_expect("t4_rd2", 1'b1);
    pop_expect("t4_rd3", 1'b1);

    // T5: mid-word pause and precision change
    push(1'b1); push(1'b1); push(1'b0); push(1'b0);
    push(1'b1); push(1'b0); push(1'b1); push(1'b1);
    pop_expect("t5_w1_b0", 1'b1);
    pop_expect("t5_w1_b1", 1'b1);
    repeat (3) tick();
    check("t5_pause_empty", 32'(empty), 32'd0);
    precision = 5'd2;
    pop_expect("t5_w1_b2", 1'b0);
    pop_expect("t5_w1_b3", 1'b0);
    pop_expect("t5_w2_b0", 1'b1);
    pop_expect("t5_w2_b1", 1'b0);
    precision = 5'd4;
    #1;
    check("t5_word2_done", 32'(empty), 32'd1);
    precision = 5'd2;
    pop_expect("t5_w3_b0", 1'b1);
    pop_expect("t5_w3_b1", 1'b1);

    // T6: concurrent read/write with wrap, precision=1
    precision = 5'd1;
    push(1'b1); push(1'b0); push(1'b1);
    stream.push_back(1'b1); stream.push_back(1'b0); stream.push_back(1'b1);
    for (int k = 0; k < 100; k++) begin
      b = 1'($urandom_range(0, 1));
      stream.push_back(b);
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = b;
      tick();
      check("t6_stream", 32'(dout), 32'(stream[k]));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("t6_model_cnt", 32'(q.size()), 32'd3);
    check("t6_full", 32'(full), 32'd0);
    check("t6_empty", 32'(empty), 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
